// File: rtl/cell_sequencer.sv
// cell_sequencer: steps a bit-serial cell array through one instruction.
// Each bit of the instruction takes five cycles: read operand A, read
// operand B (while the cells capture A), capture B, execute, write A back.
// All strobes and the address are registered so the cell array and the
// memory see glitch-free signals that change only on the clock edge.

module cell_sequencer (
    input  logic        clk,
    input  logic        rst,

    input  logic        instValid,
    output logic        instReady,
    input  logic [11:0] addrA,
    input  logic [11:0] addrB,
    input  logic [4:0]  len,
    input  logic [3:0]  flagR,
    input  logic [3:0]  flagW,
    input  logic [3:0]  flagC,
    input  logic        sense,
    input  logic [7:0]  memTruth,
    input  logic [7:0]  flagTruth,
    input  logic [1:0]  newsDir,

    output logic [3:0]  cFlagR,
    output logic [3:0]  cFlagW,
    output logic [3:0]  cFlagC,
    output logic        cSense,
    output logic [7:0]  cMemTruth,
    output logic [7:0]  cFlagTruth,
    output logic [1:0]  cNewsDir,

    output logic [11:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    output logic        capA,
    output logic        capB,
    output logic        latch,

    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDA  = 3'd1,
        RDB  = 3'd2,
        CAPB = 3'd3,
        EXEC = 3'd4,
        WRB  = 3'd5
    } state_t;

    // Sequencing state
    state_t      state_q,   state_d;
    logic [4:0]  bit_idx_q, bit_idx_d;

    // Held instruction fields
    logic [11:0] addr_a_q,     addr_a_d;
    logic [11:0] addr_b_q,     addr_b_d;
    logic [4:0]  len_q,        len_d;
    logic [3:0]  flag_r_q,     flag_r_d;
    logic [3:0]  flag_w_q,     flag_w_d;
    logic [3:0]  flag_c_q,     flag_c_d;
    logic        sense_q,      sense_d;
    logic [7:0]  mem_truth_q,  mem_truth_d;
    logic [7:0]  flag_truth_q, flag_truth_d;
    logic [1:0]  news_dir_q,   news_dir_d;

    // Registered outputs
    logic [11:0] mem_addr_q,  mem_addr_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        cap_a_q,     cap_a_d;
    logic        cap_b_q,     cap_b_d;
    logic        latch_q,     latch_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    // Helpers
    logic        accept;
    logic        zero_len_accept;
    logic        last_bit;
    logic [11:0] next_addr_a;
    logic [11:0] next_addr_b;

    // Ready is combinational so an instruction offered while reset is high
    // is never taken, even though the state already reads IDLE.
    assign instReady = (state_q == IDLE) && !rst;

    assign accept          = instValid && instReady;
    assign zero_len_accept = accept && (len == 5'd0);
    assign last_bit        = (bit_idx_q == (len_q - 5'd1));

    // Next state, bit index and field capture for the per-bit cycle walk.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        len_d        = len_q;
        flag_r_d     = flag_r_q;
        flag_w_d     = flag_w_q;
        flag_c_d     = flag_c_q;
        sense_d      = sense_q;
        mem_truth_d  = mem_truth_q;
        flag_truth_d = flag_truth_q;
        news_dir_d   = news_dir_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_a_d     = addrA;
                    addr_b_d     = addrB;
                    len_d        = len;
                    flag_r_d     = flagR;
                    flag_w_d     = flagW;
                    flag_c_d     = flagC;
                    sense_d      = sense;
                    mem_truth_d  = memTruth;
                    flag_truth_d = flagTruth;
                    news_dir_d   = newsDir;
                    bit_idx_d    = 5'd0;
                    state_d      = (len == 5'd0) ? IDLE : RDA;
                end
            end
            RDA:  state_d = RDB;
            RDB:  state_d = CAPB;
            CAPB: state_d = EXEC;
            EXEC: state_d = WRB;
            WRB: begin
                if (last_bit) begin
                    state_d = IDLE;
                end else begin
                    bit_idx_d = bit_idx_q + 5'd1;
                    state_d   = RDA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand addresses for the bit about to be processed; 12-bit adds wrap
    // naturally from 4095 to 0.
    always_comb begin
        next_addr_a = addr_a_d + {7'd0, bit_idx_d};
        next_addr_b = addr_b_d + {7'd0, bit_idx_d};
    end

    // Outputs are decoded from the state being entered so they appear
    // registered in the same cycle the state itself is current.
    always_comb begin
        mem_addr_d  = 12'd0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        cap_a_d     = 1'b0;
        cap_b_d     = 1'b0;
        latch_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != IDLE);

        unique case (state_d)
            RDA: begin
                mem_read_d = 1'b1;
                mem_addr_d = next_addr_a;
            end
            RDB: begin
                mem_read_d = 1'b1;
                cap_a_d    = 1'b1;
                mem_addr_d = next_addr_b;
            end
            CAPB: begin
                cap_b_d = 1'b1;
            end
            EXEC: begin
                latch_d = 1'b1;
            end
            WRB: begin
                mem_write_d = 1'b1;
                mem_addr_d  = next_addr_a;
                done_d      = (bit_idx_d == (len_d - 5'd1));
            end
            default: begin
                done_d = zero_len_accept;
            end
        endcase
    end

    // Single state register for the whole sequencer; reset clears
    // everything including the held fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_idx_q    <= 5'd0;
            addr_a_q     <= 12'd0;
            addr_b_q     <= 12'd0;
            len_q        <= 5'd0;
            flag_r_q     <= 4'd0;
            flag_w_q     <= 4'd0;
            flag_c_q     <= 4'd0;
            sense_q      <= 1'b0;
            mem_truth_q  <= 8'd0;
            flag_truth_q <= 8'd0;
            news_dir_q   <= 2'd0;
            mem_addr_q   <= 12'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cap_a_q      <= 1'b0;
            cap_b_q      <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            len_q        <= len_d;
            flag_r_q     <= flag_r_d;
            flag_w_q     <= flag_w_d;
            flag_c_q     <= flag_c_d;
            sense_q      <= sense_d;
            mem_truth_q  <= mem_truth_d;
            flag_truth_q <= flag_truth_d;
            news_dir_q   <= news_dir_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            cap_a_q      <= cap_a_d;
            cap_b_q      <= cap_b_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cFlagR     = flag_r_q;
    assign cFlagW     = flag_w_q;
    assign cFlagC     = flag_c_q;
    assign cSense     = sense_q;
    assign cMemTruth  = mem_truth_q;
    assign cFlagTruth = flag_truth_q;
    assign cNewsDir   = news_dir_q;

    assign memAddr  = mem_addr_q;
    assign memRead  = mem_read_q;
    assign memWrite = mem_write_q;
    assign capA     = cap_a_q;
    assign capB     = cap_b_q;
    assign latch    = latch_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // The memory and cell strobes must never overlap.
    strobes_exclusive: assert property (@(posedge clk)
        $onehot0({mem_read_q, mem_write_q, cap_b_q, latch_q}));

    // busy mirrors the non-idle states exactly.
    busy_matches_state: assert property (@(posedge clk)
        busy_q == (state_q != IDLE));

endmodule
